// File: rtl/avalon_st_timing_adapter_rl.sv
// Avalon-ST timing adapter: show-ahead FIFO decoupling source and sink ready latencies.
// in_ready is throttled from the registered fill level so late source beats always find room.
module avalon_st_timing_adapter_rl #(
  parameter int DATA_W  = 32,
  parameter int ERROR_W = 6,
  parameter int EMPTY_W = 2,
  parameter int DEPTH   = 8,
  parameter int IN_RL   = 0,
  parameter int OUT_RL  = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         in_ready,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [ERROR_W-1:0]           in_error,
  input  logic                         in_startofpacket,
  input  logic                         in_endofpacket,
  input  logic [EMPTY_W-1:0]           in_empty,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [ERROR_W-1:0]           out_error,
  output logic                         out_startofpacket,
  output logic                         out_endofpacket,
  output logic [EMPTY_W-1:0]           out_empty,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = $clog2(DEPTH+1);
  localparam int PAY_W  = DATA_W + ERROR_W + 2 + EMPTY_W;

  logic [PAY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             grant;
  logic             push;
  logic             pop;
  logic             drop;

  assign in_ready  = fill_level < FILL_W'(DEPTH - IN_RL);
  assign out_valid = grant & (fill_level != '0);

  generate
    if (OUT_RL == 0) begin : g_rl0
      assign grant = 1'b1;
      assign pop   = out_valid & out_ready;
    end else begin : g_rlk
      // Sink committed to accept OUT_RL cycles ago, so a granted valid beat is always a pop.
      logic [OUT_RL-1:0] rdy_pipe;
      always_ff @(posedge clk) begin
        if (!reset_n) rdy_pipe <= '0;
        else          rdy_pipe <= (rdy_pipe << 1) | OUT_RL'(out_ready);
      end
      assign grant = rdy_pipe[OUT_RL-1];
      assign pop   = out_valid;
    end
  endgenerate

  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push = in_valid & ((fill_level != FILL_W'(DEPTH)) | pop);
  assign drop = in_valid & ~push;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_data, in_error, in_startofpacket, in_endofpacket, in_empty};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill_level <= fill_level + FILL_W'(1);
        2'b01:   fill_level <= fill_level - FILL_W'(1);
        default: fill_level <= fill_level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  assign {out_data, out_error, out_startofpacket, out_endofpacket, out_empty} = mem[rd_ptr];

endmodule

// File: doc/avalon_st_timing_adapter_rl.md
# avalon_st_timing_adapter_rl

Parametrised Avalon-ST timing adapter. It decouples a source and a sink that differ in ready latency and need elastic buffering between them. Payload is {data, error, startofpacket, endofpacket, empty}, carried through a show-ahead FIFO. in_ready is throttled so that the source's ready latency can never overflow the buffer. The block sits between Avalon-ST producers and consumers in the Nios/SOPC streaming fabric, wherever either side uses ready latency 0..4.

## Interface
- DATA_W, 32, data width.
- ERROR_W, 6, error width.
- EMPTY_W, 2, empty width.
- DEPTH, 8, FIFO entries. Power of 2, range 4..256, must be ≥ IN_RL+2.
- IN_RL, 0, ready latency on the in interface (0..4).
- OUT_RL, 0, ready latency on the out interface (0..4).
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_ready  out  1  adapter can accept beats IN_RL cycles later.
- in_valid  in  1  beat present.
- in_data  in  DATA_W  payload data.
- in_error  in  ERROR_W  error bits.
- in_startofpacket, in_endofpacket  in  1 each  packet delimiters.
- in_empty  in  EMPTY_W  empty symbols.
- out_ready  in  1  sink ready, interpreted with OUT_RL.
- out_valid  out  1  beat transferred this cycle.
- out_data, out_error, out_startofpacket, out_endofpacket, out_empty  out  widths as the in side  head-of-FIFO payload.
- fill_level  out  clog2(DEPTH+1)  registered entry count.
- overflow  out  1  sticky: a beat was dropped because the FIFO was full.

## Operation
- Storage is a circular buffer with write and read pointers of log2(DEPTH) bits; pointers wrap naturally. Payload RAM is not reset.
- **in_ready** is combinational: fill_level < DEPTH − IN_RL. This guarantees space for all L+1 writes that can land in cycles t..t+IN_RL after the last ready cycle t.
- **Push** happens whenever in_valid=1. The source is trusted to honour IN_RL; in_ready is not re-checked on the in side.
  - Push is accepted if fill_level < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the beat is dropped, overflow is set, and fill_level, the pointers and the RAM are unchanged.
- **Output gating with OUT_RL=0**: out_valid = (fill_level≠0). Pop = out_valid & out_ready.
- **Output gating with OUT_RL=k≥1**: a k-stage shift register rdy_pipe is loaded from out_ready. out_valid = rdy_pipe[k−1] & (fill_level≠0). Pop = out_valid; the sink is obliged to accept.
- The out payload always reflects the RAM entry at the read pointer (show-ahead). It is don't-care when out_valid=0.
- **fill_level update**:
  - +1 on an accepted push without a pop.
  - −1 on a pop without a push.
  - Unchanged on both or neither.
- Simultaneous push and pop at fill_level=DEPTH: both occur, fill stays DEPTH, and overflow is not set.
- **overflow** is cleared only by reset.
- Packet fields are passed through untouched. No SOP/EOP checking is done.

## Timing
- **Reset** (reset_n=0 sampled at a clk edge) forces:
  - fill_level=0, both pointers=0, overflow=0, rdy_pipe=0.
  - out_valid=0 in the following cycle.
  - in_ready=1 (since DEPTH>IN_RL).
- Reset mid-operation discards all buffered beats. No beat emerges after reset until a new push.
- **Latency**: a beat pushed at edge t is visible with out_valid=1 in cycle t+1 (OUT_RL=0, out_ready high). There is no combinational in→out bypass.
- **Throughput**: 1 beat/cycle sustained when both sides are continuously ready.
- in_ready reacts in the same cycle to fill_level, which is registered, so in_ready has no combinational path from in_valid or out_ready.
- With OUT_RL=k, a beat is emitted exactly k cycles after the out_ready that granted it, provided data is present then.

## Test plan
- **Reset defaults.**
  - Stimulus: reset_n low for 2 cycles, then release, with DEPTH=8, IN_RL=0.
  - Required: in_ready=1, out_valid=0, fill_level=0, overflow=0.
- **Stream ordering.**
  - Stimulus: DEPTH=8, IN_RL=0, OUT_RL=0; push 20 beats with data 0..19 and SOP on beat 0, EOP on beat 19; out_ready toggles 1,0,1,0.
  - Required: output sequence 0..19 in order with SOP/EOP on the same beats, fill_level never exceeds 8, overflow=0.
- **Ready-latency headroom.**
  - Stimulus: DEPTH=8, IN_RL=2; source pushes every cycle allowed by in_ready (2 cycles late); out_ready=0.
  - Required: in_ready deasserts when fill_level=6, exactly 8 beats stored, overflow=0.
- **Overflow.**
  - Stimulus: DEPTH=4, IN_RL=0; fill to 4, then in_valid=1 with data 0xAA and out_ready=0.
  - Required: overflow=1 from the next cycle, fill_level stays 4, 0xAA never appears on the output.
- **Full with simultaneous push and pop.**
  - Stimulus: DEPTH=4 at fill_level=4; in_valid=1 and out_ready=1 in the same cycle.
  - Required: head beat popped, new beat written, fill_level=4, overflow stays 0.
- **Output ready latency.**
  - Stimulus: OUT_RL=2 with 3 beats buffered; out_ready pulsed high for one cycle at t.
  - Required: exactly one beat with out_valid=1 at t+2, fill_level 3→2. A reset asserted at t+1 instead yields no beat and fill_level=0.
